// File: rtl/diffchk_pkg.sv
// Shared types, constants and the output-folding helper for the differential
// stimulus/checker.
package diffchk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [63:0] LFSR_MASK = 64'hD800000000000000;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_INIT = 32'hFFFFFFFF;
  localparam logic [15:0] FIDX_NONE = 16'hFFFF;
  localparam int          MAX_OUT_W = 1024;

  // Callers zero-extend y to MAX_OUT_W, so a partial top chunk is zero-padded.
  function automatic logic [31:0] fold32(input logic [MAX_OUT_W-1:0] y, input int width);
    logic [31:0] acc;
    acc = '0;
    for (int c = 0; c < MAX_OUT_W / 32; c++) begin
      if (c * 32 < width) acc = acc ^ y[c*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/diff_stim_checker_misr.sv
// 32-bit MISR compacting one wide DUT output per enabled cycle.
module misr32
  import diffchk_pkg::*;
#(
  parameter int OUT_W = 360
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] data,
  output logic [31:0]      sig
);

  logic [31:0] next_sig;

  always_comb begin
    next_sig = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0)
             ^ fold32(MAX_OUT_W'(data), OUT_W);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   sig <= MISR_INIT;
    else if (clr) sig <= MISR_INIT;
    else if (en)  sig <= next_sig;
  end

endmodule

// File: rtl/diff_stim_checker.sv
// Drives LFSR vectors to a golden model and a netlist, compares their outputs
// LAT+1 cycles later and compacts both into MISR signatures.
module diff_stim_checker
  import diffchk_pkg::*;
#(
  parameter int          IN_W    = 59,
  parameter int          OUT_W   = 360,
  parameter int          NUM_VEC = 20,
  parameter int          LAT     = 0,
  parameter logic [63:0] SEED    = 64'h8DB141E12985760E
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] y_gold,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mismatch_cnt,
  output logic [15:0]      first_fail_idx,
  output logic [31:0]      sig_gold,
  output logic [31:0]      sig_dut,
  output state_t           dbg_state
);

  localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam logic [3:0]  LAT_W    = 4'(LAT);
  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

  state_t      state, state_nxt;
  logic [63:0] lfsr, lfsr_nxt;
  logic [15:0] vec_idx;
  logic [3:0]  wait_cnt;
  logic        accept, cmp, last, diff;

  // start is honoured only outside RUN; a start on the final compare edge is lost.
  assign accept   = start && (state != RUN);
  assign cmp      = (state == RUN) && (wait_cnt == LAT_W);
  assign last     = (vec_idx == LAST_IDX);
  assign diff     = (y_gold != y_dut);
  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cmp && last) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim           <= '0;
      pass           <= 1'b0;
      mismatch_cnt   <= 16'h0;
      first_fail_idx <= FIDX_NONE;
      lfsr           <= SEED_EFF;
      vec_idx        <= 16'h0;
      wait_cnt       <= 4'h0;
    end else if (accept) begin
      stim           <= '0;
      pass           <= 1'b0;
      mismatch_cnt   <= 16'h0;
      first_fail_idx <= FIDX_NONE;
      lfsr           <= SEED_EFF;
      vec_idx        <= 16'h0;
      wait_cnt       <= 4'h0;
    end else if (state == RUN) begin
      if (!cmp) begin
        wait_cnt <= wait_cnt + 4'h1;
      end else begin
        wait_cnt <= 4'h0;
        if (diff) begin
          if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'h1;
          if (first_fail_idx == FIDX_NONE) first_fail_idx <= vec_idx;
        end
        // Final vector: pass must include this edge's compare result.
        if (last) begin
          pass <= (mismatch_cnt == 16'h0) && !diff;
        end else begin
          stim    <= lfsr_nxt[IN_W-1:0];
          lfsr    <= lfsr_nxt;
          vec_idx <= vec_idx + 16'h1;
        end
      end
    end
  end

  misr32 #(.OUT_W(OUT_W)) u_misr_gold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (cmp),
    .data  (y_gold),
    .sig   (sig_gold)
  );

  misr32 #(.OUT_W(OUT_W)) u_misr_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (cmp),
    .data  (y_dut),
    .sig   (sig_dut)
  );

endmodule

// File: tb/tb_diff_stim_checker.sv
// Scoreboard bench: four checker instances with different parameter sets,
// expected run results queued at start and compared when done rises.
module tb_diff_stim_checker;
  import diffchk_pkg::*;

  localparam logic [63:0] SEED_DEF = 64'h8DB141E12985760E;

  typedef struct packed {
    logic        pass;
    logic [15:0] cnt;
    logic [15:0] fidx;
    logic [31:0] sg;
    logic [31:0] sd;
    logic [31:0] lat;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int s_cyc_a = 0, s_cyc_b = 0, s_cyc_c = 0, s_cyc_d = 0;
  res_t exp_a_q[$], exp_b_q[$], exp_c_q[$], exp_d_q[$];
  logic [58:0] vec5_b = '0;

  // ---------------- instance a: 59->360, 20 vectors, LAT 0 ----------------
  logic [58:0]  stim_a;
  logic [359:0] yg_a, yd_a;
  logic         busy_a, done_a, pass_a;
  logic [15:0]  cnt_a, fidx_a;
  logic [31:0]  sg_a, sd_a;
  state_t       st_a;
  assign yg_a = {stim_a[5:0], {6{stim_a}}};
  assign yd_a = yg_a;

  diff_stim_checker #(.IN_W(59), .OUT_W(360), .NUM_VEC(20), .LAT(0), .SEED(SEED_DEF)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .y_gold(yg_a), .y_dut(yd_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_cnt(cnt_a), .first_fail_idx(fidx_a),
    .sig_gold(sg_a), .sig_dut(sd_a), .dbg_state(st_a));

  // ---------------- instance b: LAT 2, fault on vector 5 ----------------
  logic [58:0]  stim_b, b1 = '0, b2 = '0;
  logic [359:0] yg_b, yd_b;
  logic         busy_b, done_b, pass_b;
  logic [15:0]  cnt_b, fidx_b;
  logic [31:0]  sg_b, sd_b;
  state_t       st_b;
  always @(posedge clk) begin
    b1 <= stim_b;
    b2 <= b1;
  end
  assign yg_b = {b2[5:0], {6{b2}}};
  assign yd_b = yg_b ^ 360'(b2 == vec5_b);

  diff_stim_checker #(.IN_W(59), .OUT_W(360), .NUM_VEC(20), .LAT(2), .SEED(SEED_DEF)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .y_gold(yg_b), .y_dut(yd_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_cnt(cnt_b), .first_fail_idx(fidx_b),
    .sig_gold(sg_b), .sig_dut(sd_b), .dbg_state(st_b));

  // ---------------- instance c: 65535 vectors, always inverted ----------------
  logic [15:0] stim_c;
  logic [7:0]  yg_c, yd_c;
  logic        busy_c, done_c, pass_c;
  logic [15:0] cnt_c, fidx_c;
  logic [31:0] sg_c, sd_c;
  state_t      st_c;
  assign yg_c = stim_c[7:0];
  assign yd_c = ~yg_c;

  diff_stim_checker #(.IN_W(16), .OUT_W(8), .NUM_VEC(65535), .LAT(0), .SEED(SEED_DEF)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stim(stim_c), .y_gold(yg_c), .y_dut(yd_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch_cnt(cnt_c), .first_fail_idx(fidx_c),
    .sig_gold(sg_c), .sig_dut(sd_c), .dbg_state(st_c));

  // ---------------- instance d: SEED 0, 2 vectors, 40-bit output ----------------
  logic [63:0] stim_d;
  logic [39:0] yg_d, yd_d;
  logic        busy_d, done_d, pass_d;
  logic [15:0] cnt_d, fidx_d;
  logic [31:0] sg_d, sd_d;
  state_t      st_d;
  assign yg_d = stim_d[63:24];
  assign yd_d = yg_d;

  diff_stim_checker #(.IN_W(64), .OUT_W(40), .NUM_VEC(2), .LAT(0), .SEED(64'h0)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .stim(stim_d), .y_gold(yg_d), .y_dut(yd_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .mismatch_cnt(cnt_d), .first_fail_idx(fidx_d),
    .sig_gold(sg_d), .sig_dut(sd_d), .dbg_state(st_d));

  // ---------------- reference model ----------------
  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return l[0] ? ((l >> 1) ^ 64'hD800000000000000) : (l >> 1);
  endfunction

  function automatic logic [63:0] stim_mask(input int in_w);
    return (in_w >= 64) ? 64'hFFFFFFFFFFFFFFFF : ((64'h1 << in_w) - 64'h1);
  endfunction

  function automatic logic [63:0] model_stim(input logic [63:0] seed, input int k, input int in_w);
    logic [63:0] l;
    l = (seed == 64'h0) ? 64'h1 : seed;
    if (k == 0) return 64'h0;
    for (int i = 0; i < k; i++) l = lfsr_step(l);
    return l & stim_mask(in_w);
  endfunction

  function automatic logic [1023:0] model_gold(input int which, input logic [63:0] st);
    logic [1023:0] y;
    y = '0;
    case (which)
      0, 1:    y[359:0] = {st[5:0], {6{st[58:0]}}};
      2:       y[7:0]   = st[7:0];
      default: y[39:0]  = st[63:24];
    endcase
    return y;
  endfunction

  function automatic logic [31:0] model_misr(input logic [31:0] s, input logic [1023:0] y,
                                             input int out_w);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < out_w; i++) f[i % 32] = f[i % 32] ^ y[i];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic res_t model_run(input int which, input int nvec, input int lat,
                                     input logic [63:0] seed, input int in_w, input int out_w);
    logic [63:0]   l, st;
    logic [1023:0] yg, yd, om;
    res_t          r;
    l  = (seed == 64'h0) ? 64'h1 : seed;
    om = '0;
    for (int i = 0; i < out_w; i++) om[i] = 1'b1;
    r      = '0;
    r.fidx = 16'hFFFF;
    r.sg   = 32'hFFFFFFFF;
    r.sd   = 32'hFFFFFFFF;
    for (int k = 0; k < nvec; k++) begin
      if (k == 0) st = 64'h0;
      else begin
        l  = lfsr_step(l);
        st = l & stim_mask(in_w);
      end
      yg = model_gold(which, st);
      yd = yg;
      if (which == 1 && k == 5) yd[0] = ~yd[0];
      if (which == 2) yd = ~yg & om;
      r.sg = model_misr(r.sg, yg, out_w);
      r.sd = model_misr(r.sd, yd, out_w);
      if (yg != yd) begin
        if (r.cnt != 16'hFFFF) r.cnt = r.cnt + 16'h1;
        if (r.fidx == 16'hFFFF) r.fidx = 16'(k);
      end
    end
    r.pass = (r.cnt == 16'h0);
    r.lat  = 32'(nvec * (lat + 1));
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as expected", nm);
  endtask

  task automatic check_res(input string nm, input res_t act, input res_t exp);
    check({nm, "_pass"},  64'(act.pass), 64'(exp.pass));
    check({nm, "_cnt"},   64'(act.cnt),  64'(exp.cnt));
    check({nm, "_fidx"},  64'(act.fidx), 64'(exp.fidx));
    check({nm, "_sig_g"}, 64'(act.sg),   64'(exp.sg));
    check({nm, "_sig_d"}, 64'(act.sd),   64'(exp.sd));
    check({nm, "_lat"},   64'(act.lat),  64'(exp.lat));
  endtask

  // ---------------- monitors: pop and compare when done rises ----------------
  logic done_a_q = 1'b0, done_b_q = 1'b0, done_c_q = 1'b0, done_d_q = 1'b0;

  always @(negedge clk) begin
    done_a_q <= done_a;
    if (done_a && !done_a_q) begin
      if (exp_a_q.size() == 0) fail_now("a_unexpected_done");
      else check_res("a", {pass_a, cnt_a, fidx_a, sg_a, sd_a, 32'(cyc - s_cyc_a)}, exp_a_q.pop_front());
    end
  end

  always @(negedge clk) begin
    done_b_q <= done_b;
    if (done_b && !done_b_q) begin
      if (exp_b_q.size() == 0) fail_now("b_unexpected_done");
      else check_res("b", {pass_b, cnt_b, fidx_b, sg_b, sd_b, 32'(cyc - s_cyc_b)}, exp_b_q.pop_front());
    end
  end

  always @(negedge clk) begin
    done_c_q <= done_c;
    if (done_c && !done_c_q) begin
      if (exp_c_q.size() == 0) fail_now("c_unexpected_done");
      else check_res("c", {pass_c, cnt_c, fidx_c, sg_c, sd_c, 32'(cyc - s_cyc_c)}, exp_c_q.pop_front());
    end
  end

  always @(negedge clk) begin
    done_d_q <= done_d;
    if (done_d && !done_d_q) begin
      if (exp_d_q.size() == 0) fail_now("d_unexpected_done");
      else check_res("d", {pass_d, cnt_d, fidx_d, sg_d, sd_d, 32'(cyc - s_cyc_d)}, exp_d_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic done_of(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      2:       return done_c;
      default: return done_d;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start_a = v;
      1:       start_b = v;
      2:       start_c = v;
      default: start_d = v;
    endcase
  endtask

  // Leaves the caller 1 time unit after the edge on which start was sampled.
  task automatic launch(input int which, input bit record);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    set_start(which, 1'b0);
    if (record) begin
      case (which)
        0:       s_cyc_a = cyc;
        1:       s_cyc_b = cyc;
        2:       s_cyc_c = cyc;
        default: s_cyc_d = cyc;
      endcase
    end
  endtask

  task automatic wait_done(input int which, input int limit, input string nm);
    int i;
    i = 0;
    while (!done_of(which) && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (!done_of(which)) fail_now(nm);
  endtask

  task automatic check_reset_a(input string nm);
    check({nm, "_stim"}, 64'(stim_a), 64'h0);
    check({nm, "_busy"}, 64'(busy_a), 64'h0);
    check({nm, "_done"}, 64'(done_a), 64'h0);
    check({nm, "_pass"}, 64'(pass_a), 64'h0);
    check({nm, "_cnt"},  64'(cnt_a),  64'h0);
    check({nm, "_fidx"}, 64'(fidx_a), 64'hFFFF);
    check({nm, "_sg"},   64'(sg_a),   64'hFFFFFFFF);
    check({nm, "_sd"},   64'(sd_a),   64'hFFFFFFFF);
    check({nm, "_st"},   64'(st_a),   64'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec5_b = 59'(model_stim(SEED_DEF, 5, 59));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_a("reset");

    // Clean run, start on the final compare edge is dropped.
    exp_a_q.push_back(model_run(0, 20, 0, SEED_DEF, 59, 360));
    launch(0, 1'b1);
    check("a_v0_stim", 64'(stim_a), 64'h0);
    check("a_v0_busy", 64'(busy_a), 64'h1);
    check("a_v0_state", 64'(st_a), 64'(RUN));
    @(posedge clk); #1;
    check("a_v1_stim", 64'(stim_a), 64'h06D8A0F094C2BB07);
    repeat (18) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("a_last_done", 64'(done_a), 64'h1);
    check("a_last_busy", 64'(busy_a), 64'h0);
    @(posedge clk); #1;
    check("a_late_start_done", 64'(done_a), 64'h1);
    check("a_late_start_busy", 64'(busy_a), 64'h0);
    check("a_cnt_hand", 64'(cnt_a), 64'h0);
    check("a_fidx_hand", 64'(fidx_a), 64'hFFFF);
    check("a_pass_hand", 64'(pass_a), 64'h1);
    check("a_sig_equal", 64'(sg_a), 64'(sd_a));

    // Single-vector fault with LAT=2.
    exp_b_q.push_back(model_run(1, 20, 2, SEED_DEF, 59, 360));
    launch(1, 1'b1);
    wait_done(1, 100, "b_done_timeout");
    check("b_cnt_hand", 64'(cnt_b), 64'h1);
    check("b_fidx_hand", 64'(fidx_b), 64'h5);
    check("b_pass_hand", 64'(pass_b), 64'h0);
    check("b_sig_differ", 64'(sg_b != sd_b), 64'h1);

    // Reset at vector 7 together with start: reset wins, then a clean rerun.
    launch(0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    start_a = 1'b0;
    check_reset_a("mid_rst");
    exp_a_q.push_back(model_run(0, 20, 0, SEED_DEF, 59, 360));
    launch(0, 1'b1);
    @(posedge clk); #1;
    check("rerun_v1_stim", 64'(stim_a), 64'h06D8A0F094C2BB07);
    wait_done(0, 40, "rerun_done_timeout");

    // Start while busy is ignored; start in DONE restarts from vector 0.
    exp_a_q.push_back(model_run(0, 20, 0, SEED_DEF, 59, 360));
    launch(0, 1'b1);
    repeat (4) @(posedge clk);
    launch(0, 1'b0);
    check("busy_pulse_busy", 64'(busy_a), 64'h1);
    check("busy_pulse_vec5", 64'(stim_a), model_stim(SEED_DEF, 5, 59));
    wait_done(0, 40, "busy_pulse_done_timeout");
    exp_a_q.push_back(model_run(0, 20, 0, SEED_DEF, 59, 360));
    launch(0, 1'b1);
    check("restart_v0_stim", 64'(stim_a), 64'h0);
    check("restart_done_low", 64'(done_a), 64'h0);
    @(posedge clk); #1;
    check("restart_v1_stim", 64'(stim_a), 64'h06D8A0F094C2BB07);
    wait_done(0, 40, "restart_done_timeout");

    // Saturation over the full 65535-vector run.
    exp_c_q.push_back(model_run(2, 65535, 0, SEED_DEF, 16, 8));
    launch(2, 1'b1);
    wait_done(2, 70000, "c_done_timeout");
    check("c_cnt_hand", 64'(cnt_c), 64'hFFFF);
    check("c_fidx_hand", 64'(fidx_c), 64'h0);

    // Zero seed is replaced by 1.
    exp_d_q.push_back(model_run(3, 2, 0, 64'h0, 64, 40));
    launch(3, 1'b1);
    check("d_v0_stim", stim_d, 64'h0);
    @(posedge clk); #1;
    check("d_v1_stim", stim_d, 64'hD800000000000000);
    wait_done(3, 10, "d_done_timeout");
    check("d_stim_hold", stim_d, 64'hD800000000000000);

    repeat (3) @(negedge clk);
    check("queues_drained", 64'(exp_a_q.size() + exp_b_q.size() + exp_c_q.size() + exp_d_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/diff_stim_checker.md
Name: diff_stim_checker

Overview:
- Synthesizable differential stimulus/checker; next generation of our fixed-vector, strobe-and-diff simulation benches.
- Drives a parametrised LFSR stimulus vector into a golden model and a synthesized netlist in parallel.
- Samples both outputs after a configurable latency, compares them, and compacts each into a MISR signature.
- Sits on the fuzzing harness top, between the run controller and the two `top` instances (pre- and post-synthesis).

Parameters:
- IN_W, 59, stimulus width (concatenated DUT inputs); 1..64.
- OUT_W, 360, DUT output width; 1..1024.
- NUM_VEC, 20, vectors per run; 1..65535. Vector 0 is always all-zero.
- LAT, 0, DUT register latency in clocks; 0..15.
- SEED, 64'h8DB141E12985760E, LFSR seed; 0 is replaced by 1.

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle run request
- stim  out  IN_W  stimulus to both DUTs, registered
- y_gold  in  OUT_W  golden model output
- y_dut  in  OUT_W  synthesized netlist output
- busy  out  1  run in progress
- done  out  1  run finished, held until next accepted start
- pass  out  1  valid when done; 1 = no mismatch
- mismatch_cnt  out  16  mismatching vectors, saturating
- first_fail_idx  out  16  index of first mismatching vector; 16'hFFFF = none
- sig_gold  out  32  MISR signature of y_gold
- sig_dut  out  32  MISR signature of y_dut

Behaviour:
- Reset (rst_n=0 at posedge), applies immediately including mid-run:
  - state=IDLE; stim=0; busy=0; done=0; pass=0; mismatch_cnt=0; first_fail_idx=16'hFFFF; sig_*=32'hFFFFFFFF.
  - LFSR=SEED (or 1 if SEED is 0); vec_idx=0; wait counter=0.
- States:
  - IDLE: start=1 goes to RUN.
  - RUN: steps through vectors.
  - DONE: start=1 goes to RUN; otherwise holds.
- Accepting start, at edge S:
  - Clear counters, signatures and done; first_fail_idx=FFFF; busy=1.
  - stim=0 (vector 0); vec_idx=0; LFSR reloaded to seed.
- Timing: each vector occupies LAT+1 cycles. Vector k is compared at edge S+(k+1)(LAT+1).
- On a compare edge, same edge for all of the following:
  - MISR update for both signatures.
  - If y_gold != y_dut: mismatch_cnt += 1 (saturating at FFFF); if first_fail_idx==FFFF, capture vec_idx.
  - If vec_idx < NUM_VEC-1: stim = next LFSR word [IN_W-1:0], LFSR advances, vec_idx += 1.
- After the last compare, at edge S+NUM_VEC(LAT+1):
  - state=DONE; busy=0; done=1; pass = (final mismatch_cnt==0).
  - stim holds the last vector.
- LFSR: 64-bit Galois, right-shift. lsb=1 XORs mask 64'hD800000000000000. The first stim after vector 0 is the word after one shift from seed.
- MISR (each side): sig' = {sig[30:0],0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold(y).
  - fold = XOR of all 32-bit chunks of y.
  - Top chunk is zero-padded when OUT_W is not a multiple of 32.
- Boundaries:
  - start while busy: ignored.
  - start at the same edge as the final compare: ignored; done still rises.
  - start in DONE: restarts with an identical sequence (deterministic from seed).
  - rst_n low together with start: reset wins.
  - NUM_VEC=1: only the zero vector is applied.
  - mismatch_cnt sticks at FFFF once saturated.

Decomposition:
- Package diffchk_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - LFSR_MASK, MISR_POLY, MISR_INIT, FIDX_NONE constants;
  - fold32 function parametrised on width.
- Sub-module misr32, instantiated twice (gold and dut). Ports: clk, rst_n, clr, en, data[OUT_W], sig[32].
- FSM, LFSR and counters stay in the top module.

Test Plan:
- y_dut tied to y_gold, NUM_VEC=20, LAT=0 -> done exactly 20 cycles after start; pass=1; mismatch_cnt=0; first_fail_idx=FFFF; sig_gold==sig_dut.
- y_dut = y_gold ^ 1 only while vec_idx==5, LAT=2 -> done at 60 cycles; pass=0; mismatch_cnt=1; first_fail_idx=5; sig_gold!=sig_dut.
- y_dut = ~y_gold always, NUM_VEC=65535 -> mismatch_cnt=FFFF; first_fail_idx=0.
- Assert rst_n low at vector 7, then start again -> every output at its reset value on the reset edge; second run's stim sequence and signatures match a clean run bit-for-bit.
- Pulse start while busy, and again in DONE -> first pulse has no effect on busy, vec_idx or done timing; second restarts with vector 0 = 0 and first LFSR stim equal to the model value.
- SEED=0, NUM_VEC=2 -> stim sequence is 0, then the shift of 64'h1 (stim[IN_W-1:0] of 64'hD800000000000000).
